// File: rtl/mm2s_pkg.sv
// Shared types and configuration helpers for the C-matrix result drain (mm2s_c).
package mm2s_pkg;

  localparam int M_DEF = 8;
  localparam int N_DEF = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int depth_of(input int m, input int n);
    return (m * m) / n;
  endfunction

  // Banks must split the matrix evenly into power-of-2 depths; elements fit a 32-bit beat.
  function automatic bit cfg_ok(input int m, input int n, input int cw);
    int d;
    d = depth_of(m, n);
    return (n >= 2) && (d > 0) && ((d & (d - 1)) == 0) && (n * d == m * m) &&
           (cw >= 1) && (cw <= 32);
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry fall-through skid buffer; the source throttles itself using count.
module axis_skid2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign m_valid = (cnt_q != 2'd0) || s_valid;
  assign m_data  = (cnt_q != 2'd0) ? e0_q : (s_valid ? s_data : '0);
  assign count   = cnt_q;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    pop   = m_valid && m_ready;
    case (cnt_q)
      2'd0: begin
        if (s_valid && !pop) begin
          e0_d  = s_data;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (s_valid && pop) begin
          e0_d = s_data;
        end else if (s_valid) begin
          e1_d  = s_data;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (s_valid) e1_d = s_data;
          else         cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mm2s_c.sv
// Captures the C result matrix into N banks, then streams it out linearly over AXI4-Stream.
module mm2s_c
  import mm2s_pkg::*;
#(
  parameter int M   = M_DEF,
  parameter int N   = N_DEF,
  parameter int C_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N-1:0]                c_wr_en,
  input  logic [$clog2(M*M/N)-1:0]    c_wr_addr,
  input  logic [N-1:0][C_W-1:0]       c_wr_data,
  input  logic                        c_done,
  output logic                        c_ready,
  output logic                        busy,
  output logic                        overrun,
  output logic [31:0]                 m_axis_mm2s_tdata,
  output logic [3:0]                  m_axis_mm2s_tkeep,
  output logic                        m_axis_mm2s_tlast,
  output logic                        m_axis_mm2s_tvalid,
  input  logic                        m_axis_mm2s_tready
);

  localparam int DEPTH_C = depth_of(M, N);
  localparam int AW      = $clog2(DEPTH_C);
  localparam int PW      = $clog2(M * M);
  localparam int BW      = PW - AW;
  localparam logic [PW-1:0] LAST_PTR = PW'(M * M - 1);

  if (!cfg_ok(M, N, C_W)) begin : g_cfg_err
    $error("mm2s_c: M*M/N must be a power of 2, N >= 2 and C_W <= 32");
  end

  state_t          state_q, state_d;
  logic            c_ready_q, c_ready_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            all_rd_q, all_rd_d;
  logic            inflight_q, inflight_d;
  logic            last_q, last_d;
  logic [BW-1:0]   bank_sel_q, bank_sel_d;
  logic            issue, wr_ok, last_beat;
  logic [N-1:0][C_W-1:0] rd_bus;
  logic [C_W-1:0]  rd_sel;
  logic [32:0]     skid_in, skid_out;
  logic [1:0]      skid_cnt;

  for (genvar gi = 0; gi < N; gi++) begin : g_bank
    logic [C_W-1:0] mem [DEPTH_C];
    logic [C_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (wr_ok && c_wr_en[gi]) mem[c_wr_addr] <= c_wr_data[gi];
      if (issue) rd_q <= mem[rd_ptr_q[AW-1:0]];
    end
    assign rd_bus[gi] = rd_q;
  end

  assign rd_sel  = rd_bus[bank_sel_q];
  assign skid_in = {last_q, 32'(rd_sel)};

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    all_rd_d   = all_rd_q;
    bank_sel_d = bank_sel_q;
    wr_ok      = (state_q == FILL);
    // Reads are credit-limited so the skid buffer can absorb every in-flight beat.
    issue      = (state_q == DRAIN) && !all_rd_q &&
                 (({1'b0, skid_cnt} + {2'b00, inflight_q}) < 3'd2);
    inflight_d = issue;
    last_d     = issue && (rd_ptr_q == LAST_PTR);
    last_beat  = m_axis_mm2s_tvalid && m_axis_mm2s_tready && m_axis_mm2s_tlast;
    overrun_d  = overrun_q || ((state_q == DRAIN) && ((|c_wr_en) || c_done));
    if (issue) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      bank_sel_d = rd_ptr_q[PW-1:AW];
      if (rd_ptr_q == LAST_PTR) all_rd_d = 1'b1;
    end
    case (state_q)
      FILL:  if (c_done) state_d = DRAIN;
      DRAIN: begin
        if (last_beat) begin
          state_d  = FILL;
          rd_ptr_d = '0;
          all_rd_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
    c_ready_d = (state_d == FILL);
    busy_d    = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      c_ready_q  <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_ptr_q   <= '0;
      all_rd_q   <= 1'b0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
      bank_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      c_ready_q  <= c_ready_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      rd_ptr_q   <= rd_ptr_d;
      all_rd_q   <= all_rd_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
      bank_sel_q <= bank_sel_d;
    end
  end

  axis_skid2 #(.W(33)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (inflight_q),
    .s_data  (skid_in),
    .m_valid (m_axis_mm2s_tvalid),
    .m_data  (skid_out),
    .m_ready (m_axis_mm2s_tready),
    .count   (skid_cnt)
  );

  assign m_axis_mm2s_tdata = skid_out[31:0];
  assign m_axis_mm2s_tlast = skid_out[32];
  assign m_axis_mm2s_tkeep = 4'hF;
  assign c_ready           = c_ready_q;
  assign busy              = busy_q;
  assign overrun           = overrun_q;

endmodule
